// File: rtl/simple_ram_arbiter.sv
// simple_ram_arbiter: round-robin, lockable arbiter sharing one simple_ram among nreq clients
module simple_ram_arbiter #(
    parameter int width   = 8,
    parameter int widthad = 10,
    parameter int nreq    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [nreq-1:0]         req,
    input  logic [nreq-1:0]         req_we,
    input  logic [nreq-1:0]         req_lock,
    input  logic [nreq*widthad-1:0] req_addr,
    input  logic [nreq*width-1:0]   req_wdata,
    output logic [nreq-1:0]         gnt,
    output logic [nreq-1:0]         rsp_valid,
    output logic [width-1:0]        rsp_data,
    output logic                    ram_wren,
    output logic [widthad-1:0]      ram_wraddress,
    output logic [width-1:0]        ram_data,
    output logic [widthad-1:0]      ram_rdaddress,
    input  logic [width-1:0]        ram_q
);
    localparam int pw = $clog2(nreq);
    logic [pw-1:0] ptr, owner, win;
    logic          owner_v, hold, any, wr, rd;
    // Pick the winner: a lock in force (owner requesting or still holding lock) pins
    // the grant to the owner, otherwise the first requester at or above the pointer.
    always_comb begin
        hold = owner_v && (req[owner] || req_lock[owner]);
        any  = 1'b0;
        win  = '0;
        if (hold) begin
            any = req[owner];
            win = owner;
        end else begin
            for (int k = nreq - 1; k >= 0; k--) begin
                if (req[(int'(ptr) + k) % nreq]) begin
                    any = 1'b1;
                    win = pw'((int'(ptr) + k) % nreq);
                end
            end
        end
        if (!rst_n) any = 1'b0;
    end
    assign gnt           = any ? nreq'(1) << win : '0;
    assign wr            = any && req_we[win];
    assign rd            = any && !req_we[win];
    assign ram_wren      = wr;
    assign ram_wraddress = wr ? req_addr[win*widthad +: widthad] : '0;
    assign ram_data      = wr ? req_wdata[win*width +: width] : '0;
    assign ram_rdaddress = rd ? req_addr[win*widthad +: widthad] : '0;
    assign rsp_data      = ram_q;
    // Pointer, lock ownership and the one-cycle read response tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            owner     <= '0;
            owner_v   <= 1'b0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= rd ? gnt : '0;
            if (any) begin
                if (!(hold && req_lock[win])) ptr <= (win == pw'(nreq - 1)) ? '0 : win + 1'b1;
                owner   <= win;
                owner_v <= req_lock[win];
            end else if (owner_v && !hold) begin
                owner_v <= 1'b0;
            end
        end
    end
endmodule
